// File: rtl/store_ctrl_pkg.sv
// Shared constants, FSM state type and sizing helper for the vector-store sequencer.
package store_ctrl_pkg;

    localparam int NSIG          = 31;
    localparam int REGLD_PER_CLK = 4;

    function automatic int beat_bytes(input int nsig, input int per_clk);
        return per_clk * (nsig + 1) / 8;
    endfunction

    localparam int STORE_BEAT_BYTES = beat_bytes(NSIG, REGLD_PER_CLK);
    localparam int MAX_STORE_BEATS  = 16 / REGLD_PER_CLK;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_WR,
        ST_DONE
    } store_ctrl_state_e;

endpackage

// File: rtl/store_ctrl_addr_gen.sv
// Store address generator: latches base and beat count at accept, steps the beat
// index per accepted write and produces base + beat*BEAT_BYTES (wraps modulo 2^ADDR_W).
module store_ctrl_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 2,
    parameter int BEAT_BYTES = 16,
    parameter int MAX_BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic              i_wide,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_base;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] r_last_idx;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_beat     <= '0;
            r_last_idx <= '0;
        end else if (i_accept) begin
            r_base     <= i_base;
            r_beat     <= '0;
            r_last_idx <= i_wide ? BEAT_W'(MAX_BEATS - 1) : BEAT_W'(MAX_BEATS / 2 - 1);
        end else if (i_advance) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    assign o_addr = r_base + (ADDR_W'(r_beat) * ADDR_W'(BEAT_BYTES));
    assign o_beat = r_beat;
    assign o_last = (r_beat == r_last_idx);

endmodule

// File: rtl/store_ctrl.sv
// Vector-store sequencer: register file -> memory, one beat per RD/LAT/WR round.
// Optional stall counter output enabled by defining STORE_CTRL_STALL_CNT_EN.
module store_ctrl #(
    parameter int NSIG          = store_ctrl_pkg::NSIG,
    parameter int REGLD_PER_CLK = store_ctrl_pkg::REGLD_PER_CLK,
    parameter int ADDR_W        = 32,
    parameter int REG_IDX_W     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [REG_IDX_W-1:0]           req_reg_i,
    input  logic [ADDR_W-1:0]              req_addr_i,
    input  logic                           req_wide_i,
    output logic                           rf_rd_en_o,
    output logic [REG_IDX_W-1:0]           rf_rd_reg_o,
    output logic [1:0]                     rf_rd_beat_o,
    input  logic [REGLD_PER_CLK-1:0][NSIG:0] rf_rd_data_i,
    output logic                           mem_wr_valid_o,
    input  logic                           mem_wr_ready_i,
    output logic [ADDR_W-1:0]              mem_wr_addr_o,
    output logic [REGLD_PER_CLK-1:0][NSIG:0] mem_wr_data_o,
    output logic                           busy_o,
    output logic                           done_o
`ifdef STORE_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt_o
`endif
);

    import store_ctrl_pkg::*;

    localparam int BEAT_BYTES = beat_bytes(NSIG, REGLD_PER_CLK);
    localparam int MAX_BEATS  = 16 / REGLD_PER_CLK;
    localparam int BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    store_ctrl_state_e               r_state;
    store_ctrl_state_e               w_next;
    logic [REG_IDX_W-1:0]            r_reg;
    logic [REGLD_PER_CLK-1:0][NSIG:0] r_data;
    logic                            w_accept;
    logic                            w_handshake;
    logic                            w_last;
    logic [BEAT_W-1:0]               w_beat;
    logic [ADDR_W-1:0]               w_addr;

    assign w_accept    = (r_state == ST_IDLE) && req_valid_i;
    assign w_handshake = (r_state == ST_WR) && mem_wr_ready_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (req_valid_i) w_next = ST_RD;
            ST_RD:   w_next = ST_LAT;
            ST_LAT:  w_next = ST_WR;
            ST_WR:   if (mem_wr_ready_i) w_next = w_last ? ST_DONE : ST_RD;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg  <= '0;
            r_data <= '0;
        end else begin
            if (w_accept)            r_reg  <= req_reg_i;
            if (r_state == ST_LAT)   r_data <= rf_rd_data_i;
        end
    end

    store_ctrl_addr_gen #(
        .ADDR_W     (ADDR_W),
        .BEAT_W     (BEAT_W),
        .BEAT_BYTES (BEAT_BYTES),
        .MAX_BEATS  (MAX_BEATS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_accept  (w_accept),
        .i_wide    (req_wide_i),
        .i_base    (req_addr_i),
        .i_advance (w_handshake && !w_last),
        .o_addr    (w_addr),
        .o_beat    (w_beat),
        .o_last    (w_last)
    );

    // Read-port address lines are only driven while a read is issued.
    assign req_ready_o    = (r_state == ST_IDLE);
    assign busy_o         = (r_state != ST_IDLE);
    assign rf_rd_en_o     = (r_state == ST_RD);
    assign rf_rd_reg_o    = (r_state == ST_RD) ? r_reg : '0;
    assign rf_rd_beat_o   = (r_state == ST_RD) ? 2'(w_beat) : 2'b00;
    assign mem_wr_valid_o = (r_state == ST_WR);
    assign mem_wr_addr_o  = w_addr;
    assign mem_wr_data_o  = r_data;
    assign done_o         = (r_state == ST_DONE);

`ifdef STORE_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_accept)
            r_stall_cnt <= '0;
        else if ((r_state == ST_WR) && !mem_wr_ready_i && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_store_ctrl.sv
// Directed self-checking bench for store_ctrl (32-bit lanes, 4 lanes per beat, 16-byte beats).
module tb_store_ctrl;

    localparam int NSIG = 31;
    localparam int RPC  = 4;
    localparam int AW   = 32;
    localparam int RW   = 5;
    localparam int BB   = RPC * (NSIG + 1) / 8;

    typedef logic [RPC-1:0][NSIG:0] beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [RW-1:0] req_reg_i = '0;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_wide_i = 1'b0;
    logic          rf_rd_en_o;
    logic [RW-1:0] rf_rd_reg_o;
    logic [1:0]    rf_rd_beat_o;
    beat_t         rf_rd_data_i = '0;
    logic          mem_wr_valid_o;
    logic          mem_wr_ready_i = 1'b1;
    logic [AW-1:0] mem_wr_addr_o;
    beat_t         mem_wr_data_o;
    logic          busy_o;
    logic          done_o;
`ifdef STORE_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    store_ctrl #(
        .NSIG          (NSIG),
        .REGLD_PER_CLK (RPC),
        .ADDR_W        (AW),
        .REG_IDX_W     (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_reg_i      (req_reg_i),
        .req_addr_i     (req_addr_i),
        .req_wide_i     (req_wide_i),
        .rf_rd_en_o     (rf_rd_en_o),
        .rf_rd_reg_o    (rf_rd_reg_o),
        .rf_rd_beat_o   (rf_rd_beat_o),
        .rf_rd_data_i   (rf_rd_data_i),
        .mem_wr_valid_o (mem_wr_valid_o),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
`ifdef STORE_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Register-file content: lane n of register r holds {r, 0xA5, n}.
    function automatic beat_t make_beat(input logic [RW-1:0] r, input int beat);
        beat_t d;
        for (int i = 0; i < RPC; i++) d[i] = {8'(r), 8'hA5, 16'(beat * RPC + i)};
        return d;
    endfunction

    // Register-file read port with one cycle of latency.
    always @(posedge clk) begin
        if (rf_rd_en_o) rf_rd_data_i <= make_beat(rf_rd_reg_o, int'(rf_rd_beat_o));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request (accept at cycle 0) and check every cycle until one past done.
    // Beat sb sees mem_wr_ready_i low for L cycles starting at its first WR cycle.
    task automatic run_store(input string name, input logic [RW-1:0] r, input logic [AW-1:0] a,
                             input logic wide, input int sb, input int L);
        int nb       = wide ? 4 : 2;
        int done_exp = 3 * nb + 1 + L;
        req_reg_i   = r;
        req_addr_i  = a;
        req_wide_i  = wide;
        req_valid_i = 1'b1;
        mem_wr_ready_i = 1'b1;
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got %b want 1", name, req_ready_o);
        end
        step();
        // Inputs now change but must be ignored while busy.
        req_reg_i  = ~r;
        req_addr_i = ~a;
        req_wide_i = ~wide;
        for (int c = 1; c <= done_exp + 1; c++) begin
            logic          exp_valid = 1'b0;
            logic          exp_rd    = 1'b0;
            int            wk        = 0;
            int            rk        = 0;
            logic [AW-1:0] ea;
            for (int k = 0; k < nb; k++) begin
                int sh = (k > sb) ? L : 0;
                int ws = 3 + 3 * k + sh;
                int we = ws + ((k == sb) ? L : 0);
                if (c == 1 + 3 * k + sh) begin exp_rd = 1'b1; rk = k; end
                if (c >= ws && c <= we) begin exp_valid = 1'b1; wk = k; end
            end
            mem_wr_ready_i = (sb >= 0 && c >= 3 + 3 * sb && c < 3 + 3 * sb + L) ? 1'b0 : 1'b1;
            if (c == done_exp) req_valid_i = 1'b0;
            #1;
            n_tests++;
            if (mem_wr_valid_o !== exp_valid) begin
                n_fail++;
                $display("FAIL %s wr_valid c=%0d: got %b want %b", name, c, mem_wr_valid_o, exp_valid);
            end
            if (exp_valid) begin
                ea = a + AW'(wk * BB);
                n_tests++;
                if (mem_wr_addr_o !== ea) begin
                    n_fail++;
                    $display("FAIL %s wr_addr c=%0d: got %h want %h", name, c, mem_wr_addr_o, ea);
                end
                n_tests++;
                if (mem_wr_data_o !== make_beat(r, wk)) begin
                    n_fail++;
                    $display("FAIL %s wr_data c=%0d: got %h want %h", name, c, mem_wr_data_o, make_beat(r, wk));
                end
            end
            n_tests++;
            if (rf_rd_en_o !== exp_rd) begin
                n_fail++;
                $display("FAIL %s rd_en c=%0d: got %b want %b", name, c, rf_rd_en_o, exp_rd);
            end
            if (exp_rd) begin
                n_tests++;
                if (rf_rd_reg_o !== r || rf_rd_beat_o !== 2'(rk)) begin
                    n_fail++;
                    $display("FAIL %s rd_reg_beat c=%0d: got %0d/%0d want %0d/%0d",
                             name, c, rf_rd_reg_o, rf_rd_beat_o, r, rk);
                end
            end
            n_tests++;
            if (done_o !== (c == done_exp)) begin
                n_fail++;
                $display("FAIL %s done c=%0d: got %b want %b", name, c, done_o, (c == done_exp));
            end
            n_tests++;
            if (busy_o !== (c <= done_exp) || req_ready_o !== (c > done_exp)) begin
                n_fail++;
                $display("FAIL %s busy_ready c=%0d: got %b/%b want %b/%b",
                         name, c, busy_o, req_ready_o, (c <= done_exp), (c > done_exp));
            end
            @(posedge clk);
            #1;
        end
        mem_wr_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if (done_o !== 1'b0 || rf_rd_en_o !== 1'b0 || rf_rd_reg_o !== '0 || rf_rd_beat_o !== 2'b00 ||
            mem_wr_addr_o !== '0 || mem_wr_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b rd_en=%b reg=%0d beat=%0d addr=%h data=%h want all 0",
                     done_o, rf_rd_en_o, rf_rd_reg_o, rf_rd_beat_o, mem_wr_addr_o, mem_wr_data_o);
        end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_wr_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got ready=%b busy=%b valid=%b want 1/0/0",
                         c, req_ready_o, busy_o, mem_wr_valid_o);
            end
            step();
        end
    endtask

    task automatic test_store8();
        run_store("store8", 5'd3, 32'h0000_1000, 1'b0, -1, 0);
    endtask

    task automatic test_store16();
        run_store("store16", 5'd12, 32'h0000_2000, 1'b1, -1, 0);
    endtask

    task automatic test_back_pressure();
        run_store("backpressure", 5'd9, 32'h0000_4000, 1'b0, 1, 5);
`ifdef STORE_CTRL_STALL_CNT_EN
        n_tests++;
        if (stall_cnt_o !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want 5", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_addr_wrap();
        run_store("wrap", 5'd7, 32'hFFFF_FFF0, 1'b1, -1, 0);
    endtask

    task automatic test_reset_mid();
        req_reg_i   = 5'd4;
        req_addr_i  = 32'h0000_3000;
        req_wide_i  = 1'b0;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        for (int c = 2; c <= 6; c++) step();
        mem_wr_ready_i = 1'b0;
        n_tests++;
        if (mem_wr_valid_o !== 1'b1 || mem_wr_addr_o !== 32'h0000_3010) begin
            n_fail++;
            $display("FAIL rstmid_in_wr: got valid=%b addr=%h want 1/00003010", mem_wr_valid_o, mem_wr_addr_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_wr_ready_i = 1'b1;
        n_tests++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_wr_valid_o !== 1'b0 || done_o !== 1'b0 ||
            rf_rd_en_o !== 1'b0 || mem_wr_addr_o !== '0 || mem_wr_data_o !== '0) begin
            n_fail++;
            $display("FAIL rstmid_state: got ready=%b busy=%b valid=%b done=%b rd=%b addr=%h data=%h want reset values",
                     req_ready_o, busy_o, mem_wr_valid_o, done_o, rf_rd_en_o, mem_wr_addr_o, mem_wr_data_o);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_tests++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet c=%0d: got done=%b busy=%b want 0/0", c, done_o, busy_o);
            end
        end
        run_store("after_rst", 5'd21, 32'h0000_5000, 1'b0, -1, 0);
    endtask

    initial begin
        #1;
        test_reset();
        test_store8();
        test_store16();
        test_back_pressure();
        test_addr_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
